// File: rtl/dnn_pkg.sv
// Shared widths and saturating arithmetic helpers for the neuron datapath.
// Helpers work on 64-bit containers, so callers keep widths up to 63 bits.
package dnn_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    // Clamp a 65-bit signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_lim(input logic signed [64:0] v,
                                                   input int unsigned w);
        logic signed [64:0] mx;
        logic signed [64:0] mn;
        mx = (65'sd1 <<< (w - 1)) - 65'sd1;
        mn = -(65'sd1 <<< (w - 1));
        if (v > mx)
            sat_lim = mx[63:0];
        else if (v < mn)
            sat_lim = mn[63:0];
        else
            sat_lim = v[63:0];
    endfunction

    // a + b, clamped to the signed range of a w-bit word (never wraps).
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned w);
        logic signed [64:0] s;
        s = $signed({a[63], a}) + $signed({b[63], b});
        sat_add = sat_lim(s, w);
    endfunction

    // Width-reducing saturate: clamp v to the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                      input int unsigned w);
        sat_narrow = sat_lim($signed({v[63], v}), w);
    endfunction

endpackage

// File: rtl/neuron_mac_sat.sv
// Combinational saturate from a 2*dataWidth signed value down to dataWidth.
module neuron_mac_sat
    import dnn_pkg::*;
#(
    parameter int dataWidth = DATA_W
) (
    input  logic signed [2*dataWidth-1:0] din,
    output logic signed [dataWidth-1:0]   dout
);

    logic signed [63:0] narrowed;
    logic               unused_hi;

    // Clamp into the narrow range, then keep the low word
    always_comb begin
        narrowed = sat_narrow(64'(din), dataWidth);
        dout     = narrowed[dataWidth-1:0];
    end

    assign unused_hi = ^narrowed[63:dataWidth];

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate core: fetches weights, accumulates saturated
// Q-format products and emits one saturated sum per vector.
// Optional feature macro: BIAS_ADD_EN (adds bias in the output stage).
module neuron_mac
    import dnn_pkg::*;
#(
    parameter int numWeight    = 3,
    parameter int addressWidth = 10,
    parameter int dataWidth    = DATA_W,
    parameter int fracBits     = FRAC_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [dataWidth-1:0] x_in,
    input  logic                        x_valid,
    output logic                        ren,
    output logic [addressWidth-1:0]     radd,
    input  logic signed [dataWidth-1:0] wout,
    input  logic signed [dataWidth-1:0] bias,
    output logic signed [dataWidth-1:0] y_out,
    output logic                        y_valid,
    output logic                        busy
);

    localparam int ACC_W = 2 * dataWidth;
    localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

    logic [addressWidth-1:0]    rd_ptr;
    logic [2:1]                 vld_pipe;   // [1]: x_d/wout aligned, [2]: prod_r valid
    logic [2:1]                 last_pipe;  // last-element tag riding with vld_pipe
    logic signed [dataWidth-1:0] x_d;
    logic signed [ACC_W-1:0]    prod_r;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [dataWidth-1:0] y_sat;
    logic signed [63:0]         acc_sum64;
    logic                       acc_first;  // next product starts a new vector
    logic                       acc_done;   // acc holds a finished vector sum
    logic                       unused_hi;

    assign ren  = x_valid;
    assign radd = rd_ptr;
    assign busy = (rd_ptr != '0) || (|vld_pipe) || acc_done;

    // Weight read pointer: advances per accepted element, wraps per vector
    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_ptr <= '0;
        else if (x_valid)
            rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
    end

    // Align x with the fetched weight, then register the full-width product
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            x_d       <= '0;
            prod_r    <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[1], x_valid};
            last_pipe <= {last_pipe[1], x_valid && (rd_ptr == LAST_ADDR)};
            if (x_valid)
                x_d <= x_in;
            if (vld_pipe[1])
                prod_r <= ACC_W'(x_d) * ACC_W'(wout);
        end
    end

    // Saturating accumulate of the next product
    always_comb begin
        acc_sum64 = sat_add(64'(acc), 64'(prod_r), ACC_W);
        acc_next  = acc_sum64[ACC_W-1:0];
    end

    // Accumulator: first product of a vector loads, later ones add
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            acc_first <= 1'b1;
            acc_done  <= 1'b0;
        end else begin
            acc_done <= vld_pipe[2] && last_pipe[2];
            if (vld_pipe[2]) begin
                acc       <= acc_first ? prod_r : acc_next;
                acc_first <= last_pipe[2];
            end
        end
    end

`ifdef BIAS_ADD_EN
    logic signed [63:0] bias_sum64;

    // Add the bias aligned to the product's binary point, then rescale
    always_comb begin
        bias_sum64 = sat_add(64'(acc), 64'(bias) <<< fracBits, ACC_W);
        sum        = bias_sum64[ACC_W-1:0];
        shifted    = sum >>> fracBits;
    end

    assign unused_hi = ^{acc_sum64[63:ACC_W], bias_sum64[63:ACC_W]};
`else
    // No bias: rescale the accumulator straight to the output Q format
    always_comb begin
        sum     = acc;
        shifted = sum >>> fracBits;
    end

    assign unused_hi = ^{acc_sum64[63:ACC_W], bias};
`endif

    neuron_mac_sat #(
        .dataWidth(dataWidth)
    ) u_sat (
        .din (shifted),
        .dout(y_sat)
    );

    // Output register: y_out updates only with the y_valid pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= acc_done;
            if (acc_done)
                y_out <= y_sat;
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: directed cases plus random vectors vs. arithmetic model.
module tb_neuron_mac;

    localparam int NW = 3;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int FB = 8;

    typedef logic signed [DW-1:0] s16_t;
    typedef s16_t vec_t [NW];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    s16_t          x_in = '0;
    logic          x_valid = 1'b0;
    logic          ren;
    logic [AW-1:0] radd;
    s16_t          wout = '0;
    s16_t          bias = '0;
    s16_t          y_out;
    logic          y_valid;
    logic          busy;

    s16_t wmem [4];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    s16_t yq[$];
    int   cq[$];
    int   lastq[$];

    neuron_mac #(
        .numWeight(NW), .addressWidth(AW), .dataWidth(DW), .fracBits(FB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .x_valid(x_valid),
        .ren(ren), .radd(radd), .wout(wout), .bias(bias),
        .y_out(y_out), .y_valid(y_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // weight memory, one-cycle read latency
    always @(posedge clk) if (ren) wout <= wmem[radd[1:0]];

    // result monitor
    always @(negedge clk) begin
        if (y_valid) begin
            yq.push_back(y_out);
            cq.push_back(cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint clampw(input longint v, input int w);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        return (v > mx) ? mx : ((v < mn) ? mn : v);
    endfunction

    // dot product with saturating running sum, optional bias, floor rescale
    function automatic longint ref_y(input vec_t xs, input vec_t ws, input s16_t b);
        longint acc;
        acc = 0;
        for (int i = 0; i < NW; i++) begin
            longint p;
            p = longint'(xs[i]) * longint'(ws[i]);
            acc = (i == 0) ? p : clampw(acc + p, 2 * DW);
        end
`ifdef BIAS_ADD_EN
        acc = clampw(acc + longint'(b) * (longint'(1) <<< FB), 2 * DW);
`endif
        return clampw(acc >>> FB, DW);
    endfunction

    // gap < 0 picks a random 0..2 idle cycles after each element
    task automatic send(input vec_t xs, input int gap);
        for (int i = 0; i < NW; i++) begin
            int gg;
            gg = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            @(posedge clk); #1;
            x_valid = 1'b1;
            x_in = xs[i];
            #1;
            chk("ren", ren, 1);
            chk("radd", radd, i);
            if (i == NW - 1) lastq.push_back(cyc);
            for (int g = 0; g < gg; g++) begin
                @(posedge clk); #1;
                x_valid = 1'b0;
                x_in = s16_t'($urandom);
                #1;
                chk("ren_gap", ren, 0);
                chk("radd_hold", radd, (i + 1) % NW);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            x_valid = 1'b0;
        end
    endtask

    task automatic get_result(input string tag, input longint exp_y, output int c_obs);
        int   n;
        int   ec;
        s16_t y;
        n = 0;
        c_obs = -1;
        while (yq.size() == 0 && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_seen"}, yq.size() > 0, 1);
        ec = -1;
        if (lastq.size() > 0) ec = lastq.pop_front();
        if (yq.size() > 0) begin
            y = yq.pop_front();
            c_obs = cq.pop_front();
            chk(tag, y, exp_y);
            chk({tag, "_lat"}, c_obs, ec + 4);
        end
    endtask

    initial begin
        vec_t xa, xb, wv;
        int   c0, c1;
        longint e;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ren", ren, 0);
        chk("rst_radd", radd, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(2);

        // test 1: basic dot product
        wmem = '{16'sh0100, 16'sh0200, -16'sh0100, 16'sh0000};
        xa = '{16'sh0100, 16'sh0100, 16'sh0100};
        bias = '0;
        send(xa, 0);
        idle(1);
        get_result("t1", 512, c0);
        idle(3);
        chk("t1_hold", y_out, 512);
        chk("t1_pulse", y_valid, 0);
        chk("t1_idle_busy", busy, 0);

        // test 2: bias
        bias = 16'sh0080;
        send(xa, 0);
        idle(1);
`ifdef BIAS_ADD_EN
        get_result("t2_bias", 640, c0);
`else
        get_result("t2_bias", 512, c0);
`endif
        idle(2);
        bias = '0;

        // test 3: back-to-back vectors
        xb = '{16'sh0200, 16'sh0000, 16'sh0000};
        send(xa, 0);
        send(xb, 0);
        idle(1);
        get_result("t3_v0", 512, c0);
        get_result("t3_v1", 512, c1);
        chk("t3_spacing", c1 - c0, 3);
        idle(2);

        // test 4: saturation both ways
        wmem = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh0000};
        xa = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
        send(xa, 0);
        idle(1);
        get_result("t4_pos", 32767, c0);
        xa = '{-16'sh8000, -16'sh8000, -16'sh8000};
        send(xa, 0);
        idle(1);
        get_result("t4_neg", -32768, c0);
        idle(2);

        // test 5: two idle cycles between elements
        wmem = '{16'sh0100, 16'sh0200, -16'sh0100, 16'sh0000};
        xa = '{16'sh0100, 16'sh0100, 16'sh0100};
        send(xa, 2);
        idle(1);
        get_result("t5_gaps", 512, c0);
        idle(2);

        // test 6: reset after two elements
        @(posedge clk); #1; x_valid = 1'b1; x_in = 16'sh0100;
        @(posedge clk); #1; x_valid = 1'b1; x_in = 16'sh0100;
        @(posedge clk); #1; x_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        chk("t6_busy", busy, 0);
        chk("t6_radd", radd, 0);
        idle(8);
        chk("t6_no_result", yq.size(), 0);
        send(xa, 0);
        idle(1);
        get_result("t6_after", 512, c0);
        idle(2);

        // random vectors, random gaps and bias
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NW; i++) begin
                if (r % 3 == 0) begin
                    wv[i] = s16_t'($urandom);
                    xa[i] = s16_t'($urandom);
                end else begin
                    wv[i] = s16_t'(int'($urandom_range(0, 4095)) - 2048);
                    xa[i] = s16_t'(int'($urandom_range(0, 4095)) - 2048);
                end
                wmem[i] = wv[i];
            end
            bias = s16_t'(int'($urandom_range(0, 8191)) - 4096);
            e = ref_y(xa, wv, bias);
            send(xa, (r % 2 == 1) ? -1 : 0);
            idle(1);
            get_result($sformatf("rand%0d", r), e, c0);
            idle(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
